// File: rtl/temp_cal_sequencer.sv
// temp_cal_sequencer
//   Accepts raw sensor samples, computes sample * gain + bias with an
//   iterative shift-add multiplier (one gain bit per cycle), range-checks
//   the result and returns it over a valid/ready handshake. Owns the live
//   gain/bias calibration registers.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   cfg_write/gain/bias     : load new calibration values (any state)
//   sample_valid/ready/data : raw sample handshake
//   result_valid/ready/data : calibrated result handshake
//   result_low/high         : result <= LOW_LIMIT / >= HIGH_LIMIT
//   fault_count             : saturating count of delivered out-of-range results
//   busy                    : sequencer not idle
module temp_cal_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LOW_LIMIT  = 20,
    parameter int HIGH_LIMIT = 180
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_write,
    input  logic [DATA_WIDTH-1:0]     cfg_gain,
    input  logic [DATA_WIDTH-1:0]     cfg_bias,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [DATA_WIDTH-1:0]     sample_data,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [2*DATA_WIDTH-1:0]   result_data,
    output logic                      result_low,
    output logic                      result_high,
    output logic [7:0]                fault_count,
    output logic                      busy
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        ADD    = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] gain_reg, bias_reg;
    logic [DATA_WIDTH-1:0] work_sample, work_gain, work_bias;
    logic [RW-1:0]         acc;
    logic [CW-1:0]         cnt;
    logic                  accept, deliver;

    assign accept  = sample_valid && sample_ready;
    assign deliver = result_valid && result_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        sample_ready = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                // Ready is masked during reset so no handshake is seen upstream.
                sample_ready = !reset;
                busy         = 1'b0;
                if (sample_valid) state_next = MULT;
            end
            MULT:   if (cnt == LAST_BIT) state_next = ADD;
            ADD:    state_next = RESULT;
            RESULT: begin
                result_valid = 1'b1;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result_low  = (result_data <= RW'(LOW_LIMIT));
    assign result_high = (result_data >= RW'(HIGH_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            gain_reg    <= DATA_WIDTH'(1);
            bias_reg    <= '0;
            work_sample <= '0;
            work_gain   <= '0;
            work_bias   <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_data <= '0;
            fault_count <= '0;
        end else begin
            // Working copies are taken from the pre-write register values, so a
            // write on the acceptance edge only affects the following sample.
            if (cfg_write) begin
                gain_reg <= cfg_gain;
                bias_reg <= cfg_bias;
            end
            case (state)
                IDLE: if (accept) begin
                    work_sample <= sample_data;
                    work_gain   <= gain_reg;
                    work_bias   <= bias_reg;
                    acc         <= '0;
                    cnt         <= '0;
                end
                MULT: begin
                    if (work_gain[cnt]) acc <= acc + (RW'(work_sample) << cnt);
                    cnt <= cnt + CW'(1);
                end
                ADD: result_data <= acc + RW'(work_bias);
                RESULT: if (deliver && (result_low || result_high) && (fault_count != 8'hFF))
                    fault_count <= fault_count + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
